// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: FSM encoding, command bytes, frame builder.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    // Index of the stop bit within the shifted frame (data 0-7, parity 8, stop 9).
    localparam logic [3:0] LAST_BIT_IDX = 4'd9;

    // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [9:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchroniser, run-length glitch filter, falling-edge pulse.
// Latency: 2 sync cycles + FILTER_LEN samples; no backpressure (free-running).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run;

    // An idle PS/2 line floats high, so everything resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            run   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                run <= '0;
            end else if (run == RUN_LAST) begin
                level <= sync2;
                run   <= '0;
                fall  <= level;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving the shared open-drain clock/data pads.
// Latency: INHIBIT_CYCLES + device-clocked 11-bit frame; tx_start ignored while busy.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [19:0] cnt;
    logic [3:0]  bit_idx;
    logic [9:0]  shreg;
    logic        d_oe;
    logic        done_q;
    logic        error_q;
    logic        c_level;
    logic        c_fall;
    logic        d_s1;
    logic        d_s2;
    logic        timed_out;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .line  (ps2c_in),
        .level (c_level),
        .fall  (c_fall)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
        end else begin
            d_s1 <= ps2d_in;
            d_s2 <= d_s1;
        end
    end

    // cnt restarts on entry to RTS, so this fires TIMEOUT_CYCLES after the clock release.
    assign timed_out = (cnt == TIMEOUT_LAST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (tx_start) state_nxt = ST_INHIBIT;
            ST_INHIBIT:   if (cnt == INHIBIT_LAST) state_nxt = ST_RTS;
            ST_RTS:       state_nxt = timed_out ? ST_ERROR : ST_SHIFT;
            ST_SHIFT: begin
                if (timed_out)                              state_nxt = ST_ERROR;
                else if (c_fall && bit_idx == LAST_BIT_IDX) state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (timed_out)   state_nxt = ST_ERROR;
                else if (c_fall) state_nxt = d_s2 ? ST_ERROR : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (timed_out)           state_nxt = ST_ERROR;
                else if (c_level && d_s2) state_nxt = ST_IDLE;
            end
            ST_ERROR:     state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            d_oe    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= (state == ST_WAIT_IDLE) && (state_nxt == ST_IDLE);
            error_q <= (state == ST_ERROR);

            if (state == ST_IDLE || (state == ST_INHIBIT && state_nxt == ST_RTS)) cnt <= '0;
            else cnt <= cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    bit_idx <= '0;
                    d_oe    <= 1'b0;
                    if (tx_start) shreg <= build_frame(tx_data);
                end
                ST_INHIBIT: d_oe <= (state_nxt == ST_RTS);
                ST_RTS:     bit_idx <= '0;
                ST_SHIFT: begin
                    if (c_fall && !timed_out) begin
                        d_oe    <= ~shreg[0];
                        shreg   <= {1'b0, shreg[9:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: ;
            endcase

            // Any abort releases the data line on the same edge.
            if (state_nxt == ST_ERROR || state_nxt == ST_IDLE) d_oe <= 1'b0;
        end
    end

    assign tx_ready   = (state == ST_IDLE);
    assign rx_inhibit = ~tx_ready;
    assign ps2c_oe    = (state == ST_INHIBIT) || (state == ST_RTS);
    assign ps2d_oe    = d_oe;
    assign tx_done    = done_q;
    assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks each frame and checks it against a frame scoreboard.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INHIBIT  = 50;
    localparam int TIMEOUT  = 20000;
    // Device half-period in system clocks; the system clock is scaled so a frame fits the timeout.
    localparam int DEV_HALF = 40;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready, tx_done, tx_error, rx_inhibit;
    logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
    logic       dev_clk, dev_dat;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, err_cyc = 0, pulse_bad = 0;
    logic [9:0] exp_q[$];

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Open-drain wired-AND of host and device drivers.
    assign ps2c_in = dev_clk & ~ps2c_oe;
    assign ps2d_in = dev_dat & ~ps2d_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT), .FILTER_LEN(8)) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .rx_inhibit(rx_inhibit),
        .ps2c_in   (ps2c_in),
        .ps2d_in   (ps2d_in),
        .ps2c_oe   (ps2c_oe),
        .ps2d_oe   (ps2d_oe)
    );

    always @(negedge CLOCK_50) begin
        if (resetn) begin
            if (tx_done) done_cnt++;
            if (tx_error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if ((tx_done || tx_error) && !tx_ready) pulse_bad++;
            if (tx_done && tx_error) pulse_bad++;
        end
    end

    task automatic start_tx(input logic [7:0] d, input bit track);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge CLOCK_50);
        tx_start = 1'b0;
        if (track) exp_q.push_back({1'b1, ~^d, d});
    endtask

    task automatic dev_bits(input int nbits, input int glitch_bit, output logic [9:0] got);
        got = '0;
        for (int k = 0; k < nbits; k++) begin
            dev_clk = 1'b0;
            repeat (DEV_HALF) @(negedge CLOCK_50);
            dev_clk = 1'b1;
            got[k] = ps2d_in;
            if (k == glitch_bit) begin
                repeat (15) @(negedge CLOCK_50);
                dev_clk = 1'b0;
                repeat (3) @(negedge CLOCK_50);
                dev_clk = 1'b1;
                repeat (DEV_HALF - 18) @(negedge CLOCK_50);
            end else begin
                repeat (DEV_HALF) @(negedge CLOCK_50);
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input int glitch_bit,
                             output int inh_len, output logic [9:0] got,
                             output int n_done, output int n_err);
        int d0, e0, c_cyc;
        logic [9:0] exp;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d, 1'b1);
        c_cyc = cyc;
        n_tests++;
        if (ps2c_oe !== 1'b1) begin n_fail++; $display("FAIL inhibit_start: ps2c_oe=%b want 1", ps2c_oe); end
        for (int i = 0; i < 200 && ps2d_oe !== 1'b1; i++) @(negedge CLOCK_50);
        inh_len = cyc - c_cyc;
        for (int i = 0; i < 10 && ps2c_oe !== 1'b0; i++) @(negedge CLOCK_50);
        n_tests++;
        if (ps2c_oe !== 1'b0) begin n_fail++; $display("FAIL clk_release: ps2c_oe=%b want 0", ps2c_oe); end
        repeat (DEV_HALF) @(negedge CLOCK_50);
        n_tests++;
        if (ps2d_in !== 1'b0) begin n_fail++; $display("FAIL start_bit: ps2d=%b want 0", ps2d_in); end
        dev_bits(10, glitch_bit, got);
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL scoreboard: frame %h with nothing expected", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL frame: got %h want %h", got, exp); end
        end
        if (ack) dev_dat = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        dev_clk = 1'b0;
        repeat (DEV_HALF) @(negedge CLOCK_50);
        dev_clk = 1'b1;
        repeat (DEV_HALF) @(negedge CLOCK_50);
        dev_dat = 1'b1;
        for (int i = 0; i < 200 && done_cnt == d0 && err_cnt == e0; i++) @(negedge CLOCK_50);
        repeat (5) @(negedge CLOCK_50);
        n_done = done_cnt - d0;
        n_err  = err_cnt - e0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLOCK_50);
        n_tests++;
        if ({ps2c_oe, ps2d_oe, tx_done, tx_error, rx_inhibit} !== 5'b0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: c_oe=%b d_oe=%b done=%b err=%b inh=%b ready=%b want 0,0,0,0,0,1",
                     ps2c_oe, ps2d_oe, tx_done, tx_error, rx_inhibit, tx_ready);
        end
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        n_tests++;
        if (tx_ready !== 1'b1 || ps2c_oe !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: ready=%b c_oe=%b want 1,0", tx_ready, ps2c_oe);
        end
    endtask

    task automatic test_set_leds();
        int inh, nd, ne;
        logic [9:0] got;
        run_frame(PS2_CMD_SET_LEDS, 1'b1, -1, inh, got, nd, ne);
        n_tests++;
        if (inh !== INHIBIT) begin n_fail++; $display("FAIL inhibit_len: got %0d want %0d", inh, INHIBIT); end
        n_tests++;
        if (got[7:0] !== 8'hED) begin n_fail++; $display("FAIL led_data: got %h want ed", got[7:0]); end
        n_tests++;
        if (got[9:8] !== 2'b11) begin n_fail++; $display("FAIL led_par_stop: got %b want 11", got[9:8]); end
        n_tests++;
        if (nd !== 1 || ne !== 0 || tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL led_done: done=%0d err=%0d ready=%b want 1,0,1", nd, ne, tx_ready);
        end
    endtask

    task automatic test_parity();
        logic [7:0] pats [3] = '{8'h00, 8'h01, 8'hFF};
        logic       pars [3] = '{1'b1, 1'b0, 1'b1};
        int inh, nd, ne;
        logic [9:0] got;
        for (int p = 0; p < 3; p++) begin
            run_frame(pats[p], 1'b1, -1, inh, got, nd, ne);
            n_tests++;
            if (got[8] !== pars[p]) begin
                n_fail++; $display("FAIL parity_%h: got %b want %b", pats[p], got[8], pars[p]);
            end
            n_tests++;
            if (nd !== 1 || ne !== 0) begin
                n_fail++; $display("FAIL parity_done_%h: done=%0d err=%0d want 1,0", pats[p], nd, ne);
            end
        end
    endtask

    task automatic test_no_ack();
        int inh, nd, ne;
        logic [9:0] got;
        run_frame(8'h5A, 1'b0, -1, inh, got, nd, ne);
        n_tests++;
        if (ne !== 1 || nd !== 0) begin
            n_fail++; $display("FAIL no_ack: err_cycles=%0d done=%0d want 1,0", ne, nd);
        end
        n_tests++;
        if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0 || tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL no_ack_lines: c_oe=%b d_oe=%b ready=%b want 0,0,1", ps2c_oe, ps2d_oe, tx_ready);
        end
    endtask

    task automatic test_timeout();
        int rel, e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx(8'h55, 1'b0);
        for (int i = 0; i < 200 && !(ps2c_oe === 1'b0 && ps2d_oe === 1'b1); i++) @(negedge CLOCK_50);
        rel = cyc;
        for (int i = 0; i < TIMEOUT + 5000 && err_cnt == e0; i++) @(negedge CLOCK_50);
        n_tests++;
        if (err_cnt == e0) begin
            n_fail++; $display("FAIL timeout_fired: no tx_error within %0d cycles", TIMEOUT + 5000);
        end else if (err_cyc - rel !== TIMEOUT) begin
            n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", err_cyc - rel, TIMEOUT);
        end
        repeat (3) @(negedge CLOCK_50);
        n_tests++;
        if (tx_ready !== 1'b1 || done_cnt != d0 || ps2d_oe !== 1'b0) begin
            n_fail++; $display("FAIL timeout_state: ready=%b done=%0d d_oe=%b want 1,0,0", tx_ready, done_cnt - d0, ps2d_oe);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] got, exp;
        int seen_busy;
        start_tx(8'hA5, 1'b1);
        repeat (10) @(negedge CLOCK_50);
        start_tx(8'h3C, 1'b0);
        for (int i = 0; i < 200 && !(ps2c_oe === 1'b0 && ps2d_oe === 1'b1); i++) @(negedge CLOCK_50);
        repeat (DEV_HALF) @(negedge CLOCK_50);
        dev_bits(4, -1, got);
        exp = exp_q.pop_front();
        n_tests++;
        if (got[3:0] !== exp[3:0]) begin n_fail++; $display("FAIL busy_start_ignored: bits %b want %b", got[3:0], exp[3:0]); end
        dev_clk = 1'b0;
        repeat (DEV_HALF) @(negedge CLOCK_50);
        n_tests++;
        if (ps2d_oe !== 1'b1) begin n_fail++; $display("FAIL bit4_driven: d_oe=%b want 1", ps2d_oe); end
        #3 resetn = 1'b0;
        #1;
        n_tests++;
        if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin
            n_fail++; $display("FAIL async_release: c_oe=%b d_oe=%b want 0,0", ps2c_oe, ps2d_oe);
        end
        dev_clk = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        seen_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (ps2c_oe !== 1'b0 || tx_ready !== 1'b1) seen_busy++;
        end
        n_tests++;
        if (seen_busy != 0 || rx_inhibit !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: busy_cycles=%0d inhibit=%b want 0,0", seen_busy, rx_inhibit);
        end
    endtask

    task automatic test_glitch();
        int inh, nd, ne;
        logic [9:0] got;
        run_frame(8'h96, 1'b1, 4, inh, got, nd, ne);
        n_tests++;
        if (nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL glitch_done: done=%0d err=%0d want 1,0", nd, ne); end
        n_tests++;
        if (pulse_bad != 0) begin n_fail++; $display("FAIL pulse_rules: violations=%0d want 0", pulse_bad); end
    endtask

    initial begin
        resetn   = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        test_reset();
        test_set_leds();
        test_parity();
        test_no_ack();
        test_timeout();
        test_reset_mid_frame();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
